// File: rtl/multicycle_core.sv
// Multi-cycle RV32I integer core: PC, IR, register file, ALU and a
// FETCH/DECODE/EXEC/MEM/WB controller behind one handshaked memory port.
module multicycle_core #(
   parameter int                WIDTH    = 32,
   parameter logic [WIDTH-1:0]  RESET_PC = '0,
   parameter int                NUM_REGS = 32
) (
   input  logic             clk,
   input  logic             rst,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   output logic [2:0]       mem_funct3,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_ack,
   output logic [WIDTH-1:0] pc_out,
   output logic             retire,
   output logic             halted,
   output logic             illegal
);
   if (WIDTH != 32) begin : g_width_chk
      $error("multicycle_core: WIDTH must be 32");
   end
   if (NUM_REGS != 16 && NUM_REGS != 32) begin : g_nregs_chk
      $error("multicycle_core: NUM_REGS must be 16 or 32");
   end
   if (RESET_PC[1:0] != 2'b00) begin : g_rpc_chk
      $error("multicycle_core: RESET_PC must be 4-byte aligned");
   end

   localparam int             RW   = $clog2(NUM_REGS);
   localparam logic [5:0]     NREG = 6'(NUM_REGS);
   localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                          OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                          OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011,
                          OP_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] imm_q, imm_d, alu_q, alu_d, mdr_q, mdr_d;
   logic             mem_req_q, mem_req_d, retire_q, retire_d, illegal_q, illegal_d;
   logic [WIDTH-1:0] rf_q [NUM_REGS];
   logic [WIDTH-1:0] rf_d [NUM_REGS];

   logic [6:0] opc, f7;
   logic [4:0] rd, rs1, rs2;
   logic [2:0] f3;
   assign opc = ir_q[6:0];
   assign rd  = ir_q[11:7];
   assign f3  = ir_q[14:12];
   assign rs1 = ir_q[19:15];
   assign rs2 = ir_q[24:20];
   assign f7  = ir_q[31:25];

   // Decode: legality and immediate, both consumed only in DECODE
   logic known, f_ok, use_rd, use_rs1, use_rs2, bad_instr;
   logic [WIDTH-1:0] imm_dec;
   always_comb begin
      known = 1'b1; f_ok = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b0;
      case (opc)
         OP_LUI, OP_AUIPC, OP_JAL: use_rs1 = 1'b0;
         OP_JALR:   f_ok = (f3 == 3'b000);
         OP_BRANCH: begin f_ok = (f3 != 3'b010 && f3 != 3'b011); use_rd = 1'b0; use_rs2 = 1'b1; end
         OP_LOAD:   f_ok = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
         OP_STORE:  begin f_ok = f3 inside {3'b000, 3'b001, 3'b010}; use_rd = 1'b0; use_rs2 = 1'b1; end
         OP_IMM: begin
            if (f3 == 3'b001)      f_ok = (f7 == 7'h00);
            else if (f3 == 3'b101) f_ok = (f7 == 7'h00 || f7 == 7'h20);
         end
         OP_REG: begin
            use_rs2 = 1'b1;
            f_ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
         end
         OP_SYSTEM: begin use_rd = 1'b0; use_rs1 = 1'b0; end
         default:   known = 1'b0;
      endcase
      bad_instr = !known || !f_ok ||
                  (use_rd  && {1'b0, rd}  >= NREG) ||
                  (use_rs1 && {1'b0, rs1} >= NREG) ||
                  (use_rs2 && {1'b0, rs2} >= NREG);
      case (opc)
         OP_LUI, OP_AUIPC: imm_dec = {ir_q[31:12], 12'b0};
         OP_JAL:    imm_dec = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
         OP_BRANCH: imm_dec = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
         OP_STORE:  imm_dec = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
         default:   imm_dec = {{20{ir_q[31]}}, ir_q[31:20]};
      endcase
   end

   // ALU: LUI adds the U-immediate to zero, AUIPC/JAL add it to the PC
   logic [WIDTH-1:0] op_a, op_b, res, br_tgt, pc_plus4, jtgt;
   logic             alt, taken, jump;
   always_comb begin
      op_a = (opc == OP_LUI) ? '0 : (opc == OP_AUIPC || opc == OP_JAL) ? pc_q : a_q;
      op_b = (opc == OP_REG) ? b_q : imm_q;
      alt  = f7[5] && (opc == OP_REG || (opc == OP_IMM && f3 == 3'b101));
      res  = op_a + op_b;
      if (opc == OP_REG || opc == OP_IMM) begin
         case (f3)
            3'b000: res = alt ? op_a - op_b : op_a + op_b;
            3'b001: res = op_a << op_b[4:0];
            3'b010: res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            3'b011: res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            3'b100: res = op_a ^ op_b;
            3'b101: if (alt) res = $signed(op_a) >>> op_b[4:0];
                    else     res = op_a >> op_b[4:0];
            3'b110: res = op_a | op_b;
            default: res = op_a & op_b;
         endcase
      end
      case (f3)
         3'b000:  taken = (a_q == b_q);
         3'b001:  taken = (a_q != b_q);
         3'b100:  taken = ($signed(a_q) < $signed(b_q));
         3'b101:  taken = ($signed(a_q) >= $signed(b_q));
         3'b110:  taken = (a_q < b_q);
         3'b111:  taken = (a_q >= b_q);
         default: taken = 1'b0;
      endcase
      br_tgt   = pc_q + imm_q;
      pc_plus4 = pc_q + WIDTH'(4);
      jump     = (opc == OP_JAL || opc == OP_JALR);
      jtgt     = (opc == OP_JALR) ? (res & ~WIDTH'(1)) : res;
   end

   // mem_req_d is raised on every transition into FETCH/MEM so the request
   // is registered and asserted from the first cycle of those states
   always_comb begin
      state_d = state_q; pc_d = pc_q; ir_d = ir_q; a_d = a_q; b_d = b_q;
      imm_d = imm_q; alu_d = alu_q; mdr_d = mdr_q; rf_d = rf_q;
      mem_req_d = 1'b0; retire_d = 1'b0; illegal_d = illegal_q;
      case (state_q)
         S_FETCH:
            if (mem_req_q && mem_ack) begin
               ir_d = mem_rdata; state_d = S_DECODE;
            end else mem_req_d = 1'b1;
         S_DECODE: begin
            a_d = rf_q[rs1[RW-1:0]]; b_d = rf_q[rs2[RW-1:0]]; imm_d = imm_dec;
            if (bad_instr) begin illegal_d = 1'b1; state_d = S_HALT; end
            else if (opc == OP_SYSTEM) state_d = S_HALT;
            else state_d = S_EXEC;
         end
         S_EXEC:
            if (opc == OP_BRANCH) begin
               if (taken && br_tgt[1]) begin illegal_d = 1'b1; state_d = S_HALT; end
               else begin
                  pc_d = taken ? br_tgt : pc_plus4;
                  retire_d = 1'b1; mem_req_d = 1'b1; state_d = S_FETCH;
               end
            end else if (jump && jtgt[1]) begin
               illegal_d = 1'b1; state_d = S_HALT;
            end else begin
               alu_d = jump ? jtgt : res;
               if (opc == OP_LOAD || opc == OP_STORE) begin
                  mem_req_d = 1'b1; state_d = S_MEM;
               end else state_d = S_WB;
            end
         S_MEM:
            if (mem_ack) begin
               if (opc == OP_STORE) begin
                  pc_d = pc_plus4; retire_d = 1'b1; mem_req_d = 1'b1; state_d = S_FETCH;
               end else begin
                  mdr_d = mem_rdata; state_d = S_WB;
               end
            end else mem_req_d = 1'b1;
         S_WB: begin
            if (rd[RW-1:0] != '0)
               rf_d[rd[RW-1:0]] = jump ? pc_plus4 : (opc == OP_LOAD) ? mdr_q : alu_q;
            pc_d = jump ? alu_q : pc_plus4;
            retire_d = 1'b1; mem_req_d = 1'b1; state_d = S_FETCH;
         end
         S_HALT: ;
         default: state_d = S_HALT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH; pc_q <= RESET_PC; ir_q <= '0; a_q <= '0; b_q <= '0;
         imm_q <= '0; alu_q <= '0; mdr_q <= '0;
         mem_req_q <= 1'b0; retire_q <= 1'b0; illegal_q <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
      end else begin
         state_q <= state_d; pc_q <= pc_d; ir_q <= ir_d; a_q <= a_d; b_q <= b_d;
         imm_q <= imm_d; alu_q <= alu_d; mdr_q <= mdr_d;
         mem_req_q <= mem_req_d; retire_q <= retire_d; illegal_q <= illegal_d;
         rf_q <= rf_d;
      end
   end

   assign mem_req    = mem_req_q;
   assign mem_we     = (state_q == S_MEM) && (opc == OP_STORE);
   assign mem_addr   = (state_q == S_MEM) ? alu_q : pc_q;
   assign mem_wdata  = b_q;
   assign mem_funct3 = (state_q == S_MEM) ? f3 : 3'b010;
   assign pc_out     = pc_q;
   assign retire     = retire_q;
   assign halted     = (state_q == S_HALT);
   assign illegal    = illegal_q;
endmodule
